// File: rtl/ps2_command_tx_if.sv
// PS/2 host-to-device transmitter bus: command request, raw pad inputs,
// open-drain output enables and transfer status.
`timescale 1ns/1ps
interface ps2_command_tx_if;
    logic [7:0] the_command;
    logic       send_command;
    logic       ps2_clk_in;
    logic       ps2_dat_in;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;
    logic       busy;
    logic       command_was_sent;
    logic       error_communication_timed_out;

    modport master (
        output the_command, send_command, ps2_clk_in, ps2_dat_in,
        input  ps2_clk_oe, ps2_dat_oe, busy, command_was_sent,
               error_communication_timed_out
    );

    modport slave (
        input  the_command, send_command, ps2_clk_in, ps2_dat_in,
        output ps2_clk_oe, ps2_dat_oe, busy, command_was_sent,
               error_communication_timed_out
    );
endinterface

// File: rtl/ps2_command_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send,
// 11-bit shift on device falling edges, ack check and bus-idle wait.
// Pads are driven open-drain through registered output enables.
// Optional macro PS2_TX_RETRY_EN: one automatic retry of the latched byte
// after the first NACK or timeout.
//
// state     | meaning
// S_IDLE    | bus released, waiting for send_command
// S_INHIBIT | PS2_CLK held low; start bit driven on the last cycle
// S_REQ     | clock released, start bit held, waiting for first device edge
// S_SHIFT   | driving data/parity/stop on device falling edges, then ack
// S_RELEASE | waiting for clock and data both high
// S_DONE    | command_was_sent pulse
// S_ERR     | error pulse, bus released
`timescale 1ns/1ps
module ps2_command_tx #(
    parameter int INHIBIT_CYCLES  = 6000,
    parameter int WAIT_CLK_CYCLES = 750000,
    parameter int XFER_CYCLES     = 100000
) (
    input  logic            CLOCK_50,
    input  logic            reset,
    ps2_command_tx_if.slave bus
);
    localparam int T_MAX = (INHIBIT_CYCLES > WAIT_CLK_CYCLES) ? INHIBIT_CYCLES : WAIT_CLK_CYCLES;
    localparam int TW    = $clog2(T_MAX + 1);
    localparam int XW    = $clog2(XFER_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_REQ, S_SHIFT, S_RELEASE, S_DONE, S_ERR
    } state_t;

    state_t        state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [XW-1:0] xfer_timer, xfer_n;
    logic [3:0]    bit_cnt, bit_cnt_n;
    logic [8:0]    frame, frame_n;
    logic          clk_oe_q, clk_oe_n, dat_oe_q, dat_oe_n;
    logic          busy_q, busy_n, sent_q, sent_n, err_q, err_n;
    logic          fail;
    logic          clk_meta, sync_clk, prev_clk, dat_meta, sync_dat, fall;
`ifdef PS2_TX_RETRY_EN
    logic          retry, retry_n;
`endif

    // Two-flop pad synchronizers and registered falling-edge detect on PS2_CLK
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            clk_meta <= 1'b1;
            sync_clk <= 1'b1;
            prev_clk <= 1'b1;
            dat_meta <= 1'b1;
            sync_dat <= 1'b1;
            fall     <= 1'b0;
        end else begin
            clk_meta <= bus.ps2_clk_in;
            sync_clk <= clk_meta;
            prev_clk <= sync_clk;
            dat_meta <= bus.ps2_dat_in;
            sync_dat <= dat_meta;
            fall     <= prev_clk & ~sync_clk;
        end
    end

    // State, timers, latched frame and registered outputs
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            timer      <= '0;
            xfer_timer <= '0;
            bit_cnt    <= '0;
            frame      <= '0;
            clk_oe_q   <= 1'b0;
            dat_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            sent_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            retry      <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            timer      <= timer_n;
            xfer_timer <= xfer_n;
            bit_cnt    <= bit_cnt_n;
            frame      <= frame_n;
            clk_oe_q   <= clk_oe_n;
            dat_oe_q   <= dat_oe_n;
            busy_q     <= busy_n;
            sent_q     <= sent_n;
            err_q      <= err_n;
`ifdef PS2_TX_RETRY_EN
            retry      <= retry_n;
`endif
        end
    end

    // Next-state and next-output decode; a device edge always beats a timer expiry
    always_comb begin
        state_n   = state;
        timer_n   = timer;
        xfer_n    = xfer_timer;
        bit_cnt_n = bit_cnt;
        frame_n   = frame;
        clk_oe_n  = clk_oe_q;
        dat_oe_n  = dat_oe_q;
        sent_n    = 1'b0;
        err_n     = 1'b0;
        fail      = 1'b0;
`ifdef PS2_TX_RETRY_EN
        retry_n   = retry;
`endif
        case (state)
            S_IDLE: begin
                clk_oe_n = 1'b0;
                dat_oe_n = 1'b0;
                if (bus.send_command) begin
                    frame_n   = {~^bus.the_command, bus.the_command};
                    state_n   = S_INHIBIT;
                    timer_n   = TW'(INHIBIT_CYCLES - 1);
                    bit_cnt_n = '0;
                    clk_oe_n  = 1'b1;
`ifdef PS2_TX_RETRY_EN
                    retry_n   = 1'b0;
`endif
                end
            end
            S_INHIBIT: begin
                if (timer == '0) begin
                    state_n  = S_REQ;
                    timer_n  = TW'(WAIT_CLK_CYCLES - 1);
                    clk_oe_n = 1'b0;
                    dat_oe_n = 1'b1;
                end else begin
                    timer_n = timer - TW'(1);
                    if (timer == TW'(1)) dat_oe_n = 1'b1;
                end
            end
            S_REQ: begin
                if (fall) begin
                    state_n   = S_SHIFT;
                    bit_cnt_n = 4'd1;
                    dat_oe_n  = ~frame[0];
                    xfer_n    = XW'(XFER_CYCLES - 1);
                end else if (timer == '0) begin
                    fail = 1'b1;
                end else begin
                    timer_n = timer - TW'(1);
                end
            end
            S_SHIFT: begin
                if (xfer_timer != '0) xfer_n = xfer_timer - XW'(1);
                if (fall) begin
                    bit_cnt_n = bit_cnt + 4'd1;
                    if (bit_cnt <= 4'd8) begin
                        dat_oe_n = ~frame[bit_cnt];
                    end else if (bit_cnt == 4'd9) begin
                        dat_oe_n = 1'b0;
                    end else if (!sync_dat) begin
                        state_n = S_RELEASE;
                    end else begin
                        fail = 1'b1;
                    end
                end else if (xfer_timer == '0) begin
                    fail = 1'b1;
                end
            end
            S_RELEASE: begin
                if (xfer_timer != '0) xfer_n = xfer_timer - XW'(1);
                if (sync_clk && sync_dat) begin
                    state_n = S_DONE;
                    sent_n  = 1'b1;
                end else if (xfer_timer == '0) begin
                    fail = 1'b1;
                end
            end
            S_DONE, S_ERR: begin
                state_n  = S_IDLE;
                clk_oe_n = 1'b0;
                dat_oe_n = 1'b0;
            end
            default: state_n = S_IDLE;
        endcase

        if (fail) begin
`ifdef PS2_TX_RETRY_EN
            if (!retry) begin
                retry_n   = 1'b1;
                state_n   = S_INHIBIT;
                timer_n   = TW'(INHIBIT_CYCLES - 1);
                xfer_n    = '0;
                bit_cnt_n = '0;
                clk_oe_n  = 1'b1;
                dat_oe_n  = 1'b0;
            end else begin
                state_n  = S_ERR;
                clk_oe_n = 1'b0;
                dat_oe_n = 1'b0;
                err_n    = 1'b1;
            end
`else
            state_n  = S_ERR;
            clk_oe_n = 1'b0;
            dat_oe_n = 1'b0;
            err_n    = 1'b1;
`endif
        end

        busy_n = (state_n == S_INHIBIT) || (state_n == S_REQ) ||
                 (state_n == S_SHIFT)   || (state_n == S_RELEASE);
    end

    assign bus.ps2_clk_oe                    = clk_oe_q;
    assign bus.ps2_dat_oe                    = dat_oe_q;
    assign bus.busy                          = busy_q;
    assign bus.command_was_sent              = sent_q;
    assign bus.error_communication_timed_out = err_q;
endmodule

// File: tb/tb_ps2_command_tx.sv
// Directed bench for ps2_command_tx with an open-drain pad model and a
// simple PS/2 device that clocks with a 40-cycle period.
`timescale 1ns/1ps
module tb_ps2_command_tx;
    logic CLOCK_50 = 1'b0;
    logic reset;
    logic dev_clk = 1'b1;
    logic dev_dat = 1'b1;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0, inh_cnt = 0;
    logic clk_oe_prev = 1'b0;

    always #5 CLOCK_50 = ~CLOCK_50;

    ps2_command_tx_if bus();

    assign bus.ps2_clk_in = dev_clk & ~bus.ps2_clk_oe;
    assign bus.ps2_dat_in = dev_dat & ~bus.ps2_dat_oe;

    ps2_command_tx #(
        .INHIBIT_CYCLES (20),
        .WAIT_CLK_CYCLES(200),
        .XFER_CYCLES    (2000)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset   (reset),
        .bus     (bus)
    );

    // pulse and inhibit-entry counters, sampled mid-cycle
    always @(negedge CLOCK_50) begin
        if (bus.command_was_sent) done_cnt++;
        if (bus.error_communication_timed_out) err_cnt++;
        if (bus.command_was_sent && bus.error_communication_timed_out) both_cnt++;
        if (bus.ps2_clk_oe && !clk_oe_prev) inh_cnt++;
        clk_oe_prev = bus.ps2_clk_oe;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // request a send and measure the inhibit: clk_oe length and start-bit cycle
    task automatic start_send(input logic [7:0] cmd, output int low_len, output int dat_first);
        bus.the_command  = cmd;
        bus.send_command = 1'b1;
        tick();
        bus.send_command = 1'b0;
        low_len   = 0;
        dat_first = 0;
        for (int i = 1; i <= 100; i++) begin
            if (!bus.ps2_clk_oe) break;
            low_len = i;
            if (bus.ps2_dat_oe && dat_first == 0) dat_first = i;
            tick();
        end
    endtask

    // device: sample start, then 11 clock pulses, sampling on rising edges
    task automatic dev_xfer(input logic ack, output logic [10:0] got);
        got = '0;
        repeat (5) tick();
        got[0] = bus.ps2_dat_in;
        for (int k = 1; k <= 11; k++) begin
            dev_clk = 1'b0;
            repeat (20) tick();
            dev_clk = 1'b1;
            if (k <= 10) got[k] = bus.ps2_dat_in;
            if (k == 10) dev_dat = ack ? 1'b0 : 1'b1;
            if (k == 11) dev_dat = 1'b1;
            repeat (20) tick();
        end
    endtask

    task automatic run_ok(input string tag, input logic [7:0] cmd, input logic [10:0] frame_exp);
        int ll, df, d0, e0;
        logic [10:0] got;
        d0 = done_cnt;
        e0 = err_cnt;
        start_send(cmd, ll, df);
        chk($sformatf("%s_inhibit_len", tag), ll, 20);
        chk($sformatf("%s_start_cycle", tag), df, 20);
        dev_xfer(1'b1, got);
        chk($sformatf("%s_frame", tag), got, frame_exp);
        chk($sformatf("%s_sent", tag), done_cnt - d0, 1);
        chk($sformatf("%s_err", tag), err_cnt - e0, 0);
        chk($sformatf("%s_busy", tag), bus.busy, 0);
        repeat (10) tick();
    endtask

    initial begin
        int ll, df, k, d0, e0, i0;
        logic mid_busy;
        logic [10:0] got;

        bus.the_command  = 8'h00;
        bus.send_command = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge CLOCK_50);
        #1;
        chk("rst_clk_oe", bus.ps2_clk_oe, 0);
        chk("rst_dat_oe", bus.ps2_dat_oe, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_sent", bus.command_was_sent, 0);
        chk("rst_err", bus.error_communication_timed_out, 0);
        reset = 1'b0;
        repeat (5) tick();

        // stray clock edges while idle
        for (int g = 0; g < 4; g++) begin
            dev_clk = 1'b0;
            repeat (3) tick();
            dev_clk = 1'b1;
            repeat (3) tick();
        end
        repeat (5) tick();
        chk("glitch_busy", bus.busy, 0);
        chk("glitch_oe", {bus.ps2_clk_oe, bus.ps2_dat_oe}, 0);
        chk("glitch_pulses", done_cnt + err_cnt, 0);

        run_ok("cmd_ed", 8'hED, 11'b1_1_11101101_0);
        run_ok("cmd_f4", 8'hF4, 11'b1_0_11110100_0);
        run_ok("cmd_00", 8'h00, 11'b1_1_00000000_0);

        // device never clocks
        d0 = done_cnt;
        start_send(8'hF4, ll, df);
        chk("noclk_req_oe", {bus.ps2_clk_oe, bus.ps2_dat_oe}, 2'b01);
        k = 0;
        while (!bus.error_communication_timed_out && k < 1000) begin
            tick();
            k++;
        end
`ifdef PS2_TX_RETRY_EN
        chk("noclk_err_delay", k, 420);
`else
        chk("noclk_err_delay", k, 200);
`endif
        chk("noclk_oe_after", {bus.ps2_clk_oe, bus.ps2_dat_oe}, 0);
        chk("noclk_busy", bus.busy, 0);
        chk("noclk_sent", done_cnt - d0, 0);
        repeat (10) tick();

        // device NACKs
        d0 = done_cnt;
        e0 = err_cnt;
        start_send(8'h3C, ll, df);
        i0 = inh_cnt;
        dev_xfer(1'b0, got);
        chk("nack_frame", got, 11'b1_1_00111100_0);
`ifdef PS2_TX_RETRY_EN
        chk("nack_reinhibit", inh_cnt - i0, 1);
        chk("nack_busy_held", bus.busy, 1);
        dev_xfer(1'b1, got);
        chk("retry_frame", got, 11'b1_1_00111100_0);
        chk("retry_sent", done_cnt - d0, 1);
        chk("retry_err", err_cnt - e0, 0);
`else
        chk("nack_reinhibit", inh_cnt - i0, 0);
        chk("nack_err", err_cnt - e0, 1);
        chk("nack_sent", done_cnt - d0, 0);
        chk("nack_busy", bus.busy, 0);
`endif
        repeat (10) tick();

        // second request while busy is ignored
        d0 = done_cnt;
        i0 = inh_cnt;
        mid_busy = 1'b0;
        start_send(8'h55, ll, df);
        fork
            dev_xfer(1'b1, got);
            begin
                repeat (100) tick();
                bus.the_command  = 8'hFF;
                bus.send_command = 1'b1;
                mid_busy = bus.busy;
                repeat (3) tick();
                bus.send_command = 1'b0;
            end
        join
        chk("mid_busy", mid_busy, 1);
        chk("mid_frame", got, 11'b1_1_01010101_0);
        chk("mid_sent", done_cnt - d0, 1);
        repeat (30) tick();
        chk("mid_no_restart", inh_cnt - i0, 1);
        chk("mid_idle", bus.busy, 0);

        // async reset at bit n=5
        d0 = done_cnt;
        e0 = err_cnt;
        start_send(8'h00, ll, df);
        repeat (5) tick();
        for (int f = 1; f <= 5; f++) begin
            dev_clk = 1'b0;
            repeat (20) tick();
            if (f < 5) begin
                dev_clk = 1'b1;
                repeat (20) tick();
            end
        end
        chk("rst5_dat_before", bus.ps2_dat_oe, 1);
        chk("rst5_busy_before", bus.busy, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst5_oe", {bus.ps2_clk_oe, bus.ps2_dat_oe}, 0);
        chk("rst5_busy", bus.busy, 0);
        dev_clk = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        repeat (5) tick();
        chk("rst5_pulses", (done_cnt - d0) + (err_cnt - e0), 0);
        run_ok("after_rst", 8'hFF, 11'b1_1_11111111_0);

        chk("never_both", both_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ps2_command_tx.md
Name: ps2_command_tx

Overview:
- Host-to-device transmitter for the PS/2 port. It sends one command byte to the keyboard, for example 0xED (set LEDs), 0xF4 (enable) or 0xFF (reset).
- It covers the full inhibit, request-to-send, bit-shift and acknowledge sequence, with timeouts.
- It sits beside the PS/2 receive path and shares the same PS2_CLK/PS2_DAT pads. It drives the pads open-drain through output-enables; the top level builds the tri-states (oe=1 drives 0, oe=0 releases to Z).

Parameters:
- INHIBIT_CYCLES, 6000: CLOCK_50 cycles that PS2_CLK is held low before the request (120 us at 50 MHz).
- WAIT_CLK_CYCLES, 750000: limit from clock release to the first device falling edge (15 ms).
- XFER_CYCLES, 100000: limit from the first falling edge to bus-idle after the ack (2 ms).

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- the_command  in  8  command byte; sampled on accept.
- send_command  in  1  request; accepted only when busy=0.
- ps2_clk_in  in  1  raw PS2_CLK pad value.
- ps2_dat_in  in  1  raw PS2_DAT pad value.
- ps2_clk_oe  out  1  1 pulls PS2_CLK low.
- ps2_dat_oe  out  1  1 pulls PS2_DAT low.
- busy  out  1  transfer in progress.
- command_was_sent  out  1  one-cycle pulse: device acked and the bus returned idle.
- error_communication_timed_out  out  1  one-cycle pulse: timeout or NACK; transfer abandoned.

Behaviour:
- Reset (async): state=IDLE, both oe=0 (bus released immediately, including mid-transfer), busy=0, both pulses 0, counters and shift register 0.
- Input conditioning:
  - ps2_clk_in and ps2_dat_in each pass through a 2-flop synchronizer.
  - fall = prev_clk & ~sync_clk, registered.
  - Pad-to-fall latency is 3 cycles.
- Accept: in IDLE with send_command=1, latch the_command and parity = ~^the_command (odd parity). Go to INHIBIT; busy=1 from the next cycle. send_command is ignored while busy=1.
- INHIBIT: clk_oe=1, dat_oe=0 for INHIBIT_CYCLES cycles. On the last cycle, dat_oe=1 (start bit).
- REQ: clk_oe=0, dat_oe=1, timer cleared.
  - Wait for fall.
  - Timer reaching WAIT_CLK_CYCLES -> ERR.
- SHIFT: bit counter n=1..11, counting device falling edges. On each fall, drive dat_oe = ~bit:
  - n=1..8: data bits 0..7, LSB first.
  - n=9: parity bit.
  - n=10: stop bit, so dat_oe=0.
  - n=11: sample sync_dat. 0 = ACK -> RELEASE; 1 = NACK -> ERR.
  - A single XFER_CYCLES timer runs from n=1 through RELEASE; expiry -> ERR.
- RELEASE: wait until sync_clk=1 and sync_dat=1. Then go to DONE.
- DONE: command_was_sent=1 for one cycle, busy=0, return to IDLE.
- ERR: both oe=0, error_communication_timed_out=1 for one cycle, busy=0, return to IDLE.
- Simultaneous events: a fall and a timer expiry in the same cycle -> the fall wins. command_was_sent and the error pulse never assert together.
- Glitches: spurious clock edges in IDLE have no effect.
- oe outputs come straight from registers, with no combinational path from the pads.

Optional Feature:
- Macro PS2_TX_RETRY_EN.
- Defined: on the first NACK or timeout, clear the timers and restart at INHIBIT with the same latched byte. busy stays 1 and no error pulse is issued. Only a second failure pulses error_communication_timed_out. The retry flag clears on accept and on reset.
- Undefined: the first failure goes directly to ERR. No retry logic is synthesized.

Test Plan:
- Small parameters: INHIBIT_CYCLES=20, WAIT_CLK_CYCLES=200, XFER_CYCLES=2000. Device model clocks with a 40-cycle period.
- Send 0xED, device acks:
  - clk_oe low for exactly 20 cycles; dat_oe=1 from cycle 20.
  - Device samples on rising edges: 0, then bits 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - One command_was_sent pulse, busy 1->0, no error.
- Send 0xF4 -> parity bit 0; send 0x00 -> parity bit 1. Both are acked.
- Device never clocks -> the error pulse occurs exactly WAIT_CLK_CYCLES cycles after REQ entry; both oe=0 afterwards.
- Device NACKs (data high at edge 11):
  - Without the macro: one error pulse.
  - With PS2_TX_RETRY_EN: a second INHIBIT follows, then success on the retry with no error pulse.
- send_command re-asserted with 0xFF mid-transfer of 0x55 -> ignored; the device receives only 0x55.
- reset asserted at bit n=5 -> both oe=0 in the same cycle (async), busy=0. A fresh 0xFF send afterwards completes normally.
